// File: rtl/cr16_alu_if.sv
// Operand/result bundle for the CompactRISC16 ALU.
// The master drives opcode and operands; the slave (ALU) returns the registered result and status.
interface cr16_alu_if;
    logic [3:0]  I_OPCODE;
    logic [15:0] I_A;
    logic [15:0] I_B;
    logic [15:0] O_C;
    logic [4:0]  O_STATUS;

    modport master (
        output I_OPCODE, I_A, I_B,
        input  O_C, O_STATUS
    );

    modport slave (
        input  I_OPCODE, I_A, I_B,
        output O_C, O_STATUS
    );
endinterface

// File: rtl/cr16_alu.sv
// Registered 16-bit CompactRISC16 ALU: combinational datapath feeding one result/status register stage.
// Optional multiplier on opcode 2 is compiled in only when CR16_ALU_MUL_EN is defined.
module cr16_alu (
    input  logic        I_CLK,
    input  logic        I_RESET,
    cr16_alu_if.slave   bus
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_LSH  = 4'd8;
    localparam logic [3:0] OP_RSH  = 4'd9;
    localparam logic [3:0] OP_ALSH = 4'd10;
    localparam logic [3:0] OP_ARSH = 4'd11;

    logic [15:0] w_a;
    logic [15:0] w_b;
    logic [3:0]  w_amt;
    logic        w_cin;
    logic [16:0] w_sum;
    logic [15:0] w_diff;
    logic [15:0] w_c;
    logic        w_flag_c;
    logic        w_flag_l;
    logic        w_flag_f;
    logic        w_flag_z;
    logic        w_flag_n;
    logic        w_valid;

    logic [15:0] r_c;
    logic [4:0]  r_status;

    assign w_a    = bus.I_A;
    assign w_b    = bus.I_B;
    assign w_amt  = bus.I_A[3:0];
    // ADDC always adds a forced carry-in of one; the previous carry is never reused.
    assign w_cin  = (bus.I_OPCODE == OP_ADDC);
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b} + {16'd0, w_cin};
    assign w_diff = w_b - w_a;

    // Result and flag selection for the current opcode.
    always_comb begin
        w_c      = 16'h0000;
        w_flag_c = 1'b0;
        w_flag_l = 1'b0;
        w_flag_f = 1'b0;
        w_flag_n = 1'b0;
        w_valid  = 1'b0;
        case (bus.I_OPCODE)
            OP_ADD, OP_ADDC: begin
                w_c      = w_sum[15:0];
                w_flag_c = w_sum[16];
                w_flag_f = (w_a[15] == w_b[15]) && (w_sum[15] != w_a[15]);
                w_flag_n = ((w_a[15] != w_b[15]) && w_sum[15]) || (w_a[15] && w_b[15]);
                w_valid  = 1'b1;
            end
            OP_MUL: begin
`ifdef CR16_ALU_MUL_EN
                w_c     = w_a * w_b;
                w_valid = 1'b1;
`else
                w_c     = 16'h0000;
                w_valid = 1'b0;
`endif
            end
            OP_SUB: begin
                w_c      = w_diff;
                w_flag_f = (w_a[15] != w_b[15]) && (w_diff[15] != w_b[15]);
                w_flag_n = ($signed(w_b) > $signed(w_a));
                w_flag_l = (w_b > w_a);
                w_valid  = 1'b1;
            end
            OP_NOT: begin
                w_c     = ~w_a;
                w_valid = 1'b1;
            end
            OP_AND: begin
                w_c     = w_a & w_b;
                w_valid = 1'b1;
            end
            OP_OR: begin
                w_c     = w_a | w_b;
                w_valid = 1'b1;
            end
            OP_XOR: begin
                w_c     = w_a ^ w_b;
                w_valid = 1'b1;
            end
            OP_LSH, OP_ALSH: begin
                w_c     = w_b << w_amt;
                w_valid = 1'b1;
            end
            OP_RSH: begin
                w_c     = w_b >> w_amt;
                w_valid = 1'b1;
            end
            OP_ARSH: begin
                w_c     = $signed(w_b) >>> w_amt;
                w_valid = 1'b1;
            end
            default: begin
                w_c     = 16'h0000;
                w_valid = 1'b0;
            end
        endcase
    end

    // Undefined opcodes report Z = 0 even though their result is zero.
    assign w_flag_z = w_valid && (w_c == 16'h0000);

    // Output register with synchronous reset; reset overrides the sampled operation.
    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            r_c      <= 16'h0000;
            r_status <= 5'b00000;
        end else begin
            r_c      <= w_c;
            r_status <= {w_flag_n, w_flag_z, w_flag_f, w_flag_l, w_flag_c};
        end
    end

    assign bus.O_C      = r_c;
    assign bus.O_STATUS = r_status;

endmodule

// File: tb/tb_cr16_alu.sv
// Self-checking bench for cr16_alu: directed cases plus random operations against an integer reference model.
// Honours CR16_ALU_MUL_EN the same way as the design.
module tb_cr16_alu;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    cr16_alu_if alu_if ();

    cr16_alu dut (
        .I_CLK   (clk),
        .I_RESET (rst),
        .bus     (alu_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks = n_checks + 1;
        if (obs === exp_v) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Reference: returns {N,Z,F,L,C, result[15:0]} using plain integer arithmetic.
    function automatic logic [20:0] ref_alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int ua, ub, sa, sb, r, cin;
        logic [15:0] c;
        logic cf, lf, ff, nf, zf, def;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        c = 16'h0000; cf = 1'b0; lf = 1'b0; ff = 1'b0; nf = 1'b0; def = 1'b1;
        case (op)
            4'd0, 4'd1: begin
                cin = (op == 4'd1) ? 1 : 0;
                r   = ua + ub + cin;
                c   = r[15:0];
                cf  = (r > 65535);
                r   = sa + sb + cin;
                ff  = (r > 32767) || (r < -32768);
                nf  = (r < 0);
            end
            4'd2: begin
`ifdef CR16_ALU_MUL_EN
                r = ua * ub;
                c = r[15:0];
`else
                def = 1'b0;
`endif
            end
            4'd3: begin
                r  = ub - ua;
                c  = r[15:0];
                r  = sb - sa;
                ff = (r > 32767) || (r < -32768);
                nf = (sb > sa);
                lf = (ub > ua);
            end
            4'd4: c = ~a;
            4'd5: c = a & b;
            4'd6: c = a | b;
            4'd7: c = a ^ b;
            4'd8, 4'd10: begin
                r = ub * (1 << int'(a[3:0]));
                c = r[15:0];
            end
            4'd9: begin
                r = ub / (1 << int'(a[3:0]));
                c = r[15:0];
            end
            4'd11: begin
                r = sb >>> int'(a[3:0]);
                c = r[15:0];
            end
            default: def = 1'b0;
        endcase
        zf = def && (c == 16'h0000);
        return {nf, zf, ff, lf, cf, c};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        alu_if.I_OPCODE = op;
        alu_if.I_A      = a;
        alu_if.I_B      = b;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input string tag, input logic [3:0] op, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] exp_c, input logic [4:0] exp_st);
        logic [20:0] m;
        drive(op, a, b);
        m = ref_alu(op, a, b);
        check_eq({tag, "_c"},  {16'h0000, alu_if.O_C}, {16'h0000, exp_c});
        check_eq({tag, "_st"}, {27'd0, alu_if.O_STATUS}, {27'd0, exp_st});
        check_eq({tag, "_model"}, {11'd0, m}, {11'd0, exp_st, exp_c});
    endtask

    initial begin
        logic [3:0]  op;
        logic [15:0] a, b;
        logic [20:0] m;
        logic [15:0] mul_exp;
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        alu_if.I_OPCODE = 4'd0;
        alu_if.I_A      = 16'h0000;
        alu_if.I_B      = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_c",  {16'h0000, alu_if.O_C}, 32'h0000_0000);
        check_eq("reset_st", {27'd0, alu_if.O_STATUS}, 32'h0000_0000);

        // Reset held while an ADD is presented: the operation is discarded.
        drive(4'd0, 16'h0001, 16'h0001);
        check_eq("rst_add_c", {16'h0000, alu_if.O_C}, 32'h0000_0000);
        rst = 1'b0;
        drive(4'd0, 16'h0001, 16'h0001);
        check_eq("post_rst_c", {16'h0000, alu_if.O_C}, 32'h0000_0002);

        run_vec("add_ovf",   4'd0,  16'h7FFF, 16'h0001, 16'h8000, 5'b00100);
        run_vec("add_carry", 4'd0,  16'h8000, 16'h8000, 16'h0000, 5'b11101);
        run_vec("addc_wrap", 4'd1,  16'hFFFF, 16'h0000, 16'h0000, 5'b01001);
        run_vec("addc_simp", 4'd1,  16'h0002, 16'h0003, 16'h0006, 5'b00000);
        run_vec("sub_pos",   4'd3,  16'h0003, 16'h0005, 16'h0002, 5'b10010);
        run_vec("sub_neg",   4'd3,  16'hFFFF, 16'h0001, 16'h0002, 5'b10000);
        run_vec("sub_eq",    4'd3,  16'h1234, 16'h1234, 16'h0000, 5'b01000);
        run_vec("arsh",      4'd11, 16'h0004, 16'h8000, 16'hF800, 5'b00000);
        run_vec("rsh",       4'd9,  16'h0004, 16'h8000, 16'h0800, 5'b00000);
        run_vec("lsh_amt",   4'd8,  16'h0013, 16'h1234, 16'h91A0, 5'b00000);
        run_vec("not",       4'd4,  16'h00FF, 16'hABCD, 16'hFF00, 5'b00000);
        run_vec("undef15",   4'd15, 16'h1234, 16'h5678, 16'h0000, 5'b00000);
        run_vec("and_zero",  4'd5,  16'hF0F0, 16'h0F0F, 16'h0000, 5'b01000);
`ifdef CR16_ALU_MUL_EN
        mul_exp = 16'hFFFD;
`else
        mul_exp = 16'h0000;
`endif
        run_vec("mul", 4'd2, 16'hFFFF, 16'h0003, mul_exp, 5'b00000);

        // Back-to-back random operations: each cycle checked against the model.
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if (i % 8 == 0) b = a;
            drive(op, a, b);
            m = ref_alu(op, a, b);
            check_eq($sformatf("rnd%0d_op%0d_c", i, op),  {16'h0000, alu_if.O_C}, {16'h0000, m[15:0]});
            check_eq($sformatf("rnd%0d_op%0d_st", i, op), {27'd0, alu_if.O_STATUS}, {27'd0, m[20:16]});
        end

        // Mid-stream reset discards the in-flight operation.
        rst = 1'b1;
        drive(4'd7, 16'hAAAA, 16'h5555);
        check_eq("mid_rst_c",  {16'h0000, alu_if.O_C}, 32'h0000_0000);
        check_eq("mid_rst_st", {27'd0, alu_if.O_STATUS}, 32'h0000_0000);
        rst = 1'b0;
        drive(4'd7, 16'hAAAA, 16'h5555);
        check_eq("after_mid_rst_c", {16'h0000, alu_if.O_C}, 32'h0000_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
